// File: rtl/full_subtractor_pkg.sv
// Shared definitions for the ripple-borrow subtractor: default operand width
// and the {borrow, diff} result record.
package full_subtractor_pkg;

    localparam int unsigned FS_DEFAULT_WIDTH = 1;
    localparam int unsigned FS_MAX_WIDTH     = 64;

    typedef struct packed {
        logic                    borrow;
        logic [FS_MAX_WIDTH-1:0] diff;
    } fs_result_t;

    function automatic fs_result_t fs_pack(input logic borrow, input logic [FS_MAX_WIDTH-1:0] diff);
        fs_result_t r;
        r.borrow = borrow;
        r.diff   = diff;
        return r;
    endfunction

endpackage

// File: rtl/full_subtractor_cell.sv
// One-bit combinational full-subtractor cell: d = a - b - bin, bout on underflow.
module full_subtractor_cell
    import full_subtractor_pkg::*;
(
    input  logic a,
    input  logic b,
    input  logic bin,
    output logic d,
    output logic bout
);

    logic w_axb;

    assign w_axb = a ^ b;
    assign d     = w_axb ^ bin;
    assign bout  = (~a & b) | (~w_axb & bin);

endmodule

// File: rtl/full_subtractor.sv
// Registered WIDTH-bit subtractor: ripple chain of 1-bit cells computing
// {borrow, diff} = a - b - c, one result per accepted operand set.
module full_subtractor
    import full_subtractor_pkg::*;
#(
    parameter int unsigned WIDTH = FS_DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             c,
    output logic             out_valid,
    output logic [WIDTH-1:0] diff,
    output logic             borrow
);

    logic [WIDTH:0]   w_bin;
    logic [WIDTH-1:0] w_diff;

    logic             r_valid;
    logic [WIDTH-1:0] r_diff;
    logic             r_borrow;

    assign w_bin[0] = c;

    for (genvar i = 0; i < WIDTH; i++) begin : g_cell
        full_subtractor_cell u_cell (
            .a    (a[i]),
            .b    (b[i]),
            .bin  (w_bin[i]),
            .d    (w_diff[i]),
            .bout (w_bin[i+1])
        );
    end

    // Result registers only load on accepted operands, so idle-cycle inputs never reach the outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_valid  <= 1'b0;
            r_diff   <= '0;
            r_borrow <= 1'b0;
        end else begin
            r_valid <= in_valid;
            if (in_valid) begin
                r_diff   <= w_diff;
                r_borrow <= w_bin[WIDTH];
            end
        end
    end

    assign out_valid = r_valid;
    assign diff      = r_diff;
    assign borrow    = r_borrow;

endmodule

// File: tb/tb_full_subtractor.sv
// Self-checking bench: WIDTH=1 exhaustive table plus WIDTH=8 directed and
// randomized vectors checked against an arithmetic reference model.
module tb_full_subtractor;
    import full_subtractor_pkg::*;

    logic       clk = 1'b0;
    logic       rst_n;

    logic       iv8;
    logic [7:0] a8, b8;
    logic       c8;
    logic       ov8;
    logic [7:0] d8;
    logic       bo8;

    logic       iv1;
    logic [0:0] a1, b1;
    logic       c1;
    logic       ov1;
    logic [0:0] d1;
    logic       bo1;

    int unsigned n_total = 0;
    int unsigned n_pass  = 0;

    fs_result_t m_res = '0;
    logic       m_valid = 1'b0;

    full_subtractor #(.WIDTH(8)) dut8 (
        .clk(clk), .rst_n(rst_n), .in_valid(iv8), .a(a8), .b(b8), .c(c8),
        .out_valid(ov8), .diff(d8), .borrow(bo8)
    );

    full_subtractor #(.WIDTH(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .in_valid(iv1), .a(a1), .b(b1), .c(c1),
        .out_valid(ov1), .diff(d1), .borrow(bo1)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    endtask

    // Reference: plain integer arithmetic, borrow means a < b + c.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_valid <= 1'b0;
            m_res   <= '0;
        end else if (iv8) begin
            m_valid <= 1'b1;
            m_res   <= fs_pack(int'(a8) < int'(b8) + int'(c8),
                               64'((int'(a8) - int'(b8) - int'(c8)) & 255));
        end else begin
            m_valid <= 1'b0;
        end
    end

    always @(negedge clk) begin
        if (rst_n === 1'b1 || rst_n === 1'b0)
            chk("model8", 64'({ov8, bo8, d8}), 64'({m_valid, m_res.borrow, m_res.diff[7:0]}));
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set8(input logic v, input logic [7:0] a, input logic [7:0] b, input logic c);
        iv8 = v; a8 = a; b8 = b; c8 = c;
    endtask

    task automatic lit8(input string name, input logic v, input logic [7:0] d, input logic bo);
        chk(name, 64'({ov8, bo8, d8}), 64'({v, bo, d}));
    endtask

    logic [1:0] tbl1 [8];

    initial begin
        tbl1[0] = 2'b00; tbl1[1] = 2'b11; tbl1[2] = 2'b11; tbl1[3] = 2'b01;
        tbl1[4] = 2'b10; tbl1[5] = 2'b00; tbl1[6] = 2'b00; tbl1[7] = 2'b11;

        set8(1'b0, 8'h00, 8'h00, 1'b0);
        iv1 = 1'b0; a1 = 1'b0; b1 = 1'b0; c1 = 1'b0;
        rst_n = 1'b1;
        #1 rst_n = 1'b0;
        #2;
        lit8("reset8", 1'b0, 8'h00, 1'b0);
        chk("reset1", 64'({ov1, bo1, d1}), 64'(0));
        step();
        lit8("reset8_clk", 1'b0, 8'h00, 1'b0);
        #3 rst_n = 1'b1;
        step();

        // WIDTH=1 exhaustive, back-to-back
        for (int k = 0; k < 8; k++) begin
            iv1 = 1'b1;
            {a1, b1, c1} = 3'(k);
            step();
            chk($sformatf("w1_vec%0d", k), 64'({ov1, d1, bo1}), 64'({1'b1, tbl1[k]}));
        end
        iv1 = 1'b0;

        // WIDTH=8 directed
        set8(1'b1, 8'h05, 8'h03, 1'b0); step(); lit8("d8_5m3", 1'b1, 8'h02, 1'b0);
        set8(1'b1, 8'h03, 8'h05, 1'b1); step(); lit8("d8_3m5m1", 1'b1, 8'hFD, 1'b1);
        set8(1'b1, 8'hFF, 8'hFF, 1'b0); step(); lit8("d8_ffmff", 1'b1, 8'h00, 1'b0);
        set8(1'b1, 8'hFF, 8'hFF, 1'b1); step(); lit8("d8_ffmffm1", 1'b1, 8'hFF, 1'b1);
        set8(1'b1, 8'h00, 8'h00, 1'b1); step(); lit8("d8_0m0m1", 1'b1, 8'hFF, 1'b1);

        // Hold: idle cycles with changing operands leave the result intact
        for (int k = 0; k < 3; k++) begin
            set8(1'b0, 8'($urandom), 8'($urandom), 1'($urandom));
            step();
            lit8($sformatf("hold%0d", k), 1'b0, 8'hFF, 1'b1);
        end

        // Reset mid-stream: result pending, reset between edges
        set8(1'b1, 8'h05, 8'h03, 1'b0); step(); lit8("pre_rst", 1'b1, 8'h02, 1'b0);
        set8(1'b1, 8'h10, 8'h01, 1'b0);
        #2 rst_n = 1'b0;
        #1 lit8("rst_async", 1'b0, 8'h00, 1'b0);
        step();
        lit8("rst_held", 1'b0, 8'h00, 1'b0);
        rst_n = 1'b1;
        set8(1'b1, 8'h03, 8'h05, 1'b1); step(); lit8("post_rst", 1'b1, 8'hFD, 1'b1);

        // Random stream, ~80% valid so back-to-back runs are common
        for (int k = 0; k < 10000; k++) begin
            set8(($urandom_range(0, 9) < 8) ? 1'b1 : 1'b0, 8'($urandom), 8'($urandom), 1'($urandom));
            step();
        end
        set8(1'b0, 8'h00, 8'h00, 1'b0);
        step();
        step();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/full_subtractor.md
FULL_SUBTRACTOR -- requirements
Module: full_subtractor

Interface
REQ-001 Parameter: WIDTH, 1, operand width in bits (legal 1..64).
REQ-002 Port: clk  input  1  rising-edge clock; one clock domain only.
REQ-003 Port: rst_n  input  1  reset, asynchronous, active-low.
REQ-004 Port: in_valid  input  1  when high, the operands are sampled at the clk rising edge.
REQ-005 Port: a  input  WIDTH  minuend, unsigned.
REQ-006 Port: b  input  WIDTH  subtrahend, unsigned.
REQ-007 Port: c  input  1  borrow-in, subtracted at bit 0.
REQ-008 Port: out_valid  output  1  high for one cycle per accepted operand set.
REQ-009 Port: diff  output  WIDTH  registered difference.
REQ-010 Port: borrow  output  1  registered borrow-out from the MSB.

Function
REQ-011 Per bit i: d_i = a_i XOR b_i XOR bin_i; bout_i = (NOT a_i AND b_i) OR (NOT (a_i XOR b_i) AND bin_i).
REQ-012 bin_0 = c; bin_(i+1) = bout_i; borrow = bout_(WIDTH-1).
REQ-013 Arithmetic: {borrow, diff} = a - b - c, computed modulo 2^(WIDTH+1); borrow = 1 iff a < b + c (unsigned).
REQ-014 Latency 1 cycle: operands sampled at edge N with in_valid=1 appear on diff/borrow with out_valid=1 after edge N.
REQ-015 in_valid=0 at an edge: out_valid goes 0; diff and borrow hold their previous values.
REQ-016 Back-to-back in_valid=1: one result per cycle, no bubbles, no backpressure; there is no ready signal.
REQ-017 Outputs are driven only from registers; no combinational path from input to output.
REQ-018 Wrap-around: a=0, b=0, c=1 gives diff = all ones and borrow=1; a = all ones, b = all ones, c=1 gives diff = all ones and borrow=1.
REQ-019 X or Z on a, b or c while in_valid=0 shall not propagate to the outputs.

Reset
REQ-020 rst_n low immediately forces diff=0, borrow=0 and out_valid=0, independent of clk.
REQ-021 While rst_n is low, inputs are ignored and no result is produced.
REQ-022 An operand set in flight when reset asserts is discarded.
REQ-023 The first sampling edge is the first rising clk edge after rst_n deasserts.

Structure
REQ-024 Shared package full_subtractor_pkg: default WIDTH constant and the result struct type {borrow, diff}.
REQ-025 Sub-module full_subtractor_cell: a combinational 1-bit cell (a, b, bin -> d, bout) implementing REQ-011.
REQ-026 full_subtractor instantiates WIDTH cells in a generate ripple chain, followed by the output and valid registers.
REQ-027 No latches, no multicycle paths, and no other clocks.

Verification
REQ-028 WIDTH=1 exhaustive, one vector per cycle with in_valid=1; (a,b,c) -> (diff,borrow) one cycle later:
  000->00, 001->11, 010->11, 011->01, 100->10, 101->00, 110->00, 111->11.
REQ-029 WIDTH=8: a=0x05, b=0x03, c=0 -> diff=0x02, borrow=0; a=0x03, b=0x05, c=1 -> diff=0xFD, borrow=1.
REQ-030 WIDTH=8 boundary: a=0x00, b=0x00, c=1 -> diff=0xFF, borrow=1; a=0xFF, b=0xFF, c=0 -> diff=0x00, borrow=0.
REQ-031 Hold: valid result, then in_valid=0 for 3 cycles with changing a/b -> diff/borrow unchanged and out_valid=0.
REQ-032 Reset mid-stream: drop rst_n between clock edges -> outputs are 0 at once; after release, the first in_valid edge produces a correct result.
REQ-033 Random: 10k WIDTH=8 vectors compared against the a-b-c reference model, including back-to-back valid cycles.
